// File: rtl/child_fanin_collector_pkg.sv
// Shared types and helpers for the child fan-in collector.
package collector_pkg;

   localparam int CNT_W     = 16;
   localparam int MAX_CHILD = 16;

   typedef logic [$clog2(MAX_CHILD)-1:0] child_idx_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   // Round-robin pick: first set bit of req searching last+1 .. last (mod n).
   function automatic child_idx_t rr_pick(input logic [MAX_CHILD-1:0] req,
                                          input child_idx_t         last,
                                          input int                 n);
      child_idx_t pick;
      int         idx;
      pick = last;
      for (int k = MAX_CHILD; k >= 1; k--) begin
         if (k <= n) begin
            idx = int'(last) + k;
            if (idx >= n) idx = idx - n;
            if (req[child_idx_t'(idx)]) pick = child_idx_t'(idx);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/child_fanin_collector_skid_buf.sv
// Per-child skid FIFO: DEPTH entries (power of 2), registered full/empty.
module child_skid_buf
   import collector_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][DATA_W-1:0] r_mem;
   logic [PTR_W-1:0]             r_wr_ptr;
   logic [PTR_W-1:0]             r_rd_ptr;
   logic [PTR_W:0]               r_cnt;

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/child_fanin_collector.sv
// Merges NUM_CHILD child streams into one id-tagged parent stream (skid buffers + round-robin).
// Optional per-child forwarded-beat counters under COLLECTOR_STATS_EN.
module child_fanin_collector
   import collector_pkg::*;
#(
   parameter int NUM_CHILD = 5,
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CHILD-1:0]           s_valid,
   output logic [NUM_CHILD-1:0]           s_ready,
   input  logic [NUM_CHILD*DATA_W-1:0]    s_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [DATA_W-1:0]              m_data,
   output logic [$clog2(NUM_CHILD)-1:0]   m_id,
   output logic [NUM_CHILD*CNT_W-1:0]     stat_cnt
);

   localparam int ID_W = $clog2(NUM_CHILD);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   id;
   } beat_t;

   logic                             r_rdy_en;
   logic [NUM_CHILD-1:0]             w_full;
   logic [NUM_CHILD-1:0]             w_empty;
   logic [NUM_CHILD-1:0]             w_push;
   logic [NUM_CHILD-1:0]             w_pop;
   logic [NUM_CHILD-1:0][DATA_W-1:0] w_buf_data;
   logic [MAX_CHILD-1:0]             w_req;
   logic [ID_W-1:0]                  w_gnt;
   logic                             w_any;
   logic                             w_load;

   arb_state_t                       r_state;
   beat_t                            r_out;
   logic [ID_W-1:0]                  r_rr_last;

   // Inputs are refused while in reset and open the cycle after release.
   always_ff @(posedge clk) r_rdy_en <= !rst;

   for (genvar g = 0; g < NUM_CHILD; g++) begin : g_child
      assign s_ready[g] = r_rdy_en & ~rst & ~w_full[g];
      assign w_push[g]  = s_valid[g] & s_ready[g];
      assign w_pop[g]   = w_load && (w_gnt == ID_W'(g));

      child_skid_buf #(
         .DATA_W (DATA_W),
         .DEPTH  (BUF_DEPTH)
      ) u_buf (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[g]),
         .i_data  (s_data[g*DATA_W +: DATA_W]),
         .i_pop   (w_pop[g]),
         .o_data  (w_buf_data[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );
   end

   always_comb begin
      w_req                  = '0;
      w_req[NUM_CHILD-1:0]   = ~w_empty;
   end

   assign w_any  = |(~w_empty);
   assign w_gnt  = ID_W'(rr_pick(w_req, child_idx_t'(r_rr_last), NUM_CHILD));
   assign w_load = w_any && ((r_state == ARB_IDLE) || m_ready);

   // GRANT means the output register holds a beat; IDLE means it is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ARB_IDLE;
         r_out     <= '0;
         r_rr_last <= ID_W'(NUM_CHILD - 1);
      end else if (w_load) begin
         r_state    <= ARB_GRANT;
         r_out.data <= w_buf_data[w_gnt];
         r_out.id   <= w_gnt;
         r_rr_last  <= w_gnt;
      end else if (m_ready) begin
         r_state <= ARB_IDLE;
      end
   end

   assign m_valid = (r_state == ARB_GRANT);
   assign m_data  = r_out.data;
   assign m_id    = r_out.id;

`ifdef COLLECTOR_STATS_EN
   logic [NUM_CHILD-1:0][CNT_W-1:0] r_stat;

   always_ff @(posedge clk) begin
      if (rst)
         r_stat <= '0;
      else if (m_valid && m_ready)
         r_stat[r_out.id] <= r_stat[r_out.id] + CNT_W'(1);
   end

   assign stat_cnt = r_stat;
`else
   assign stat_cnt = '0;
`endif

endmodule
